uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serial UART transmitter: accepts one parallel word over a valid/ready handshake and shifts it out on tx_o.
//   Frame is start bit (0), DATA_WIDTH data bits LSB first, optional parity, then STOP_BITS stop bits (1).
//   It drives the transmit path of uart_echo and of the ALU result link to the host.
//   Default timing is 115200 baud from the 32.256 MHz board clock.
// PARAMETERS
//   DATA_WIDTH    8    data bits per frame (5..9)
//   CLKS_PER_BIT  280  clk_i cycles per bit period (>= 2)
//   STOP_BITS     1    number of stop bits (1 or 2)
//   PARITY_ODD    0    0 = even parity, 1 = odd parity; used only with UART_TX_PARITY_EN
// PORTS
//   clk_i    in   1           system clock; the only clock
//   rst_i    in   1           synchronous reset, active-high
//   data_i   in   DATA_WIDTH  word to transmit; sampled on handshake
//   valid_i  in   1           data_i valid
//   ready_o  out  1           transmitter can accept a word this cycle
//   tx_o     out  1           serial line; idles high
//   busy_o   out  1           a frame is in progress
// BEHAVIOUR
//   - Reset (rst_i high at a posedge): state IDLE, tx_o=1, busy_o=0, bit and baud counters cleared.
//     Handshakes while rst_i is high are ignored. Reset mid-frame abandons the frame: tx_o=1 the next cycle, nothing resumes.
//   - Handshake: a transfer occurs at a posedge with valid_i && ready_o. data_i is latched into the shift register on that edge.
//     Later changes to data_i do not affect the frame.
//   - ready_o is combinational from state: 1 in IDLE and in the final cycle of the last stop bit, 0 otherwise.
//   - busy_o=1 from the cycle after accept until the frame completes. It stays 1 across back-to-back frames.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or -> START on accept in the last stop cycle.
//     IDLE:   tx_o=1; on accept go to START.
//     START:  tx_o=0 for CLKS_PER_BIT cycles.
//     DATA:   tx_o=shift[0]; shift right each bit period; DATA_WIDTH bit periods.
//     PARITY: tx_o = ^data ^ PARITY_ODD for one bit period.
//     STOP:   tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - Latency: tx_o is registered and falls on the edge of the accept, i.e. visible in the first cycle after the handshake.
//   - Every bit is held exactly CLKS_PER_BIT cycles.
//     Frame period F = (1 + DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT, where P=1 if parity is enabled, else 0.
//   - Back-to-back: a word accepted in the final stop cycle starts its start bit on the next cycle. No idle gap; throughput is exactly one word per F cycles.
//   - Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Width is $clog2(CLKS_PER_BIT). Terminal count advances the bit.
//   - Bit counter counts 0..DATA_WIDTH-1 in DATA and 0..STOP_BITS-1 in STOP. It clears on every state change.
//   - valid_i high with ready_o low: the word is held off and nothing is dropped; the source must hold data_i.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state is present and P=1.
//     Default 8-bit frame: 8E1 when PARITY_ODD=0, 8O1 when PARITY_ODD=1.
//   UART_TX_PARITY_EN undefined: no PARITY state and P=0. PARITY_ODD is ignored. Default frame is 8N1.
// STRUCTURE
//   uart_pkg holds:
//     - the tx_state_e enum {IDLE, START, DATA, PARITY, STOP}
//     - CLK_FREQ_HZ=32_256_000 and BAUD=115_200
//     - the derived CLKS_PER_BIT_DEF=280, shared with the receiver
//   Sub-module uart_baud_gen: CLKS_PER_BIT counter with clear input and one-cycle tick output at terminal count.
//   Shared with the receiver.
//   uart_tx holds the FSM, shift register, bit counter and parity.
// TESTING
//   1. Reset, then accept 0xA5 (8N1).
//      tx_o = 0 for 280 cycles, then bits 1,0,1,0,0,1,0,1 for 280 cycles each, then 1.
//      ready_o returns high 2799 cycles after the accept.
//   2. valid_i held with 0x00 then 0xFF.
//      The second start bit begins exactly 2800 cycles after the first. tx_o is never high between the frames except the stop bit. busy_o stays 1.
//   3. Accept 0x3C, then change data_i to 0xC3 at cycle 500. Decoded frame is still 0x3C.
//   4. rst_i pulsed at cycle 1000 of a 0x81 frame.
//      tx_o=1 and busy_o=0 next cycle. A subsequent 0x42 transmits correctly with full-length bits.
//   5. UART_TX_PARITY_EN, send 0x07.
//      PARITY_ODD=0 gives parity bit 1; PARITY_ODD=1 gives 0. Frame is 3080 cycles.
//   6. Loop tx_o into uart_echo rx_i and send 0x00, 0x55, 0xFF. Each echo matches the word sent, checked by a bit-sampling monitor at mid-bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and board baud timing.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int unsigned CLK_FREQ_HZ = 32_256_000;
   localparam int unsigned BAUD        = 115_200;

   // 32.256 MHz / 115200 divides exactly, so no rounding error in the bit period.
   localparam int unsigned CLKS_PER_BIT_DEF = CLK_FREQ_HZ / BAUD;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick_o in the terminal-count cycle.
// clr_i holds the count at zero so the first bit after a clear is full length.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CntW'(CLKS_PER_BIT - 1));

   // Next count: wrap at terminal count, hold at zero while cleared.
   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + data (LSB first) + [parity] + stop bits out.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
// tx_o is registered from the next state so the start bit appears the cycle after accept.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic                  tx_o,
   output logic                  busy_o
);

   // Elaboration-time guards on the supported parameter ranges.
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : gen_bad_width
      $error("uart_tx: DATA_WIDTH must be 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : gen_bad_cpb
      $error("uart_tx: CLKS_PER_BIT must be >= 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD > 1) begin : gen_bad_parity
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end

   localparam logic [3:0] LastData = 4'(DATA_WIDTH - 1);
   localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic                  tx_q, tx_d;
   logic                  baud_tick;
   logic                  baud_clr;
   logic                  last_stop;
   logic                  accept;

   // Counter idles at zero so the first start bit is a full period.
   assign baud_clr = (state_q == IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (baud_clr),
      .tick_o(baud_tick)
   );

`ifdef UART_TX_PARITY_EN
   logic parity_q, parity_d;

   // Parity is computed once from the accepted word, before it is shifted away.
   always_comb begin
      parity_d = parity_q;
      if (accept) begin
         parity_d = (^data_i) ^ 1'(PARITY_ODD);
      end
   end
`endif

   // Next-state, shift register, bit counter, handshake and next serial bit.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = 1'b1;

      last_stop = (state_q == STOP) && baud_tick && (bit_cnt_q == LastStop);
      ready_o   = (state_q == IDLE) || last_stop;
      accept    = valid_i && ready_o;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = START;
               shift_d   = data_i;
               bit_cnt_d = '0;
            end
         end
         START: begin
            if (baud_tick) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LastData) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               state_d   = STOP;
               bit_cnt_d = '0;
            end
         end
`endif
         STOP: begin
            if (baud_tick) begin
               if (bit_cnt_q == LastStop) begin
                  bit_cnt_d = '0;
                  // Back-to-back accept skips IDLE entirely: no gap between frames.
                  if (accept) begin
                     state_d = START;
                     shift_d = data_i;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
         end
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   // State registers; reset abandons any frame and returns the line to idle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and random frames against a bit-list frame model.
module tb_uart_tx;

   localparam int unsigned DW   = 8;
   localparam int unsigned CPB  = 280;
   localparam int unsigned SB   = 1;
   localparam int unsigned PODD = 0;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned P = 1;
`else
   localparam int unsigned P = 0;
`endif
   localparam int unsigned NBITS = 1 + DW + P + SB;
   localparam int unsigned F     = NBITS * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic [DW-1:0] data;
   logic          tx, ready, busy;

   int checks = 0;
   int errors = 0;
   logic mid_s [NBITS];

   always #5 clk = ~clk;

   uart_tx #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (SB),
      .PARITY_ODD  (PODD)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .data_i (data),
      .valid_i(valid),
      .ready_o(ready),
      .tx_o   (tx),
      .busy_o (busy)
   );

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame as a list of line levels: start, data LSB first, optional parity, stop bits.
   function automatic logic frame_bit(input logic [DW-1:0] w, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= DW) return w[idx-1];
      if (P == 1 && idx == DW + 1) return (^w) ^ 1'(PODD);
      return 1'b1;
   endfunction

   // Line must sit idle (high, not busy, ready) for n cycles.
   task automatic idle(input int n, input string tag);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) bad++;
      end
      chk({tag, " idle_bad_cycles"}, bad, 0);
   endtask

   // Hand over w at the next edge and check every cycle of the resulting frame.
   // chain: keep valid high with w_next so it is accepted in the last stop cycle.
   // Otherwise data_i switches to w_next at cycle 500 to show the word was latched.
   task automatic tx_frame(input logic [DW-1:0] w, input bit chain, input logic [DW-1:0] w_next,
                           input string tag);
      int bad, ready_first, ready_ones, busy_bad, k;
      logic [DW-1:0] dec;
      ready_first = 0;
      ready_ones  = 0;
      busy_bad    = 0;
      chk({tag, " ready_before_accept"}, ready, 1);
      data  = w;
      valid = 1'b1;
      cycle();
      valid = chain;
      if (chain) data = w_next;
      for (int b = 0; b < int'(NBITS); b++) begin
         bad = 0;
         for (int c = 0; c < int'(CPB); c++) begin
            k = b * int'(CPB) + c + 1;
            if (tx !== frame_bit(w, b)) bad++;
            if (ready !== 1'b0) begin
               ready_ones++;
               if (ready_first == 0) ready_first = k;
            end
            if (busy !== 1'b1) busy_bad++;
            if (c == int'(CPB) / 2) mid_s[b] = tx;
            if (!chain && k == 500) data = w_next;
            if (k < int'(F)) cycle();
         end
         chk($sformatf("%s bit%0d bad_cycles", tag, b), bad, 0);
      end
      for (int i = 0; i < int'(DW); i++) dec[i] = mid_s[i+1];
      chk({tag, " ready_first_cycle"}, ready_first, F);
      chk({tag, " ready_high_cycles"}, ready_ones, 1);
      chk({tag, " busy_low_cycles"}, busy_bad, 0);
      chk({tag, " midbit_start"}, mid_s[0], 0);
      chk({tag, " midbit_word"}, dec, w);
      chk({tag, " midbit_stop"}, mid_s[NBITS-1], 1);
   endtask

   initial begin
      logic [DW-1:0] w, nxt;
      bit ch;
      rst   = 1'b1;
      valid = 1'b0;
      data  = '0;
      repeat (3) cycle();
      chk("reset tx", tx, 1);
      chk("reset busy", busy, 0);
      chk("reset ready", ready, 1);
      rst = 1'b0;
      idle(5, "post_reset");

      // Single word.
      tx_frame(8'hA5, 1'b0, 8'h5A, "t1_a5");
      idle(4, "t1");

      // Back-to-back with valid held: 0x00 then 0xFF.
      tx_frame(8'h00, 1'b1, 8'hFF, "t2_00");
      tx_frame(8'hFF, 1'b0, 8'h00, "t2_ff");
      idle(3, "t2");

      // data_i changes mid-frame.
      tx_frame(8'h3C, 1'b0, 8'hC3, "t3_3c");
      idle(3, "t3");

      // Reset mid-frame at cycle 1000, with a handshake attempted during reset.
      data  = 8'h81;
      valid = 1'b1;
      cycle();
      valid = 1'b0;
      repeat (999) cycle();
      chk("t4 tx_at_c1000", tx, frame_bit(8'h81, 999 / int'(CPB)));
      chk("t4 busy_at_c1000", busy, 1);
      rst   = 1'b1;
      valid = 1'b1;
      data  = 8'h5A;
      cycle();
      rst   = 1'b0;
      valid = 1'b0;
      chk("t4 tx_after_rst", tx, 1);
      chk("t4 busy_after_rst", busy, 0);
      chk("t4 ready_after_rst", ready, 1);
      idle(300, "t4_no_resume");
      tx_frame(8'h42, 1'b0, 8'hBD, "t4_42");
      idle(2, "t4");

`ifdef UART_TX_PARITY_EN
      tx_frame(8'h07, 1'b0, 8'hF8, "t5_07");
      chk("t5 parity_bit", mid_s[DW+1], (PODD == 0) ? 1 : 0);
      idle(2, "t5");
`endif

      // Mid-bit decoded echo words, back-to-back.
      tx_frame(8'h00, 1'b1, 8'h55, "t6_00");
      tx_frame(8'h55, 1'b1, 8'hFF, "t6_55");
      tx_frame(8'hFF, 1'b0, 8'h00, "t6_ff");
      idle(2, "t6");

      // Random words, random chaining and idle gaps.
      w = DW'($urandom);
      for (int i = 0; i < 4; i++) begin
         nxt = DW'($urandom);
         ch  = (i < 3) && ($urandom_range(0, 1) == 1);
         tx_frame(w, ch, nxt, $sformatf("rnd%0d_%02h", i, w));
         if (!ch) idle($urandom_range(1, 20), $sformatf("rnd%0d", i));
         w = nxt;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
